// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single-port data memory: 2-cycle accesses, round-robin by default.
// Define DMARB_FIXED_PRIO_EN for fixed priority (port A wins whenever both ports are eligible).
module data_mem_arbiter #(
   parameter int DEPTH  = 100,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_ack,
   output logic              a_err,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_ack,
   output logic              b_err,
   output logic [DATA_W-1:0] b_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic {IDLE, ACCESS} state_t;
   typedef enum logic {PORT_A, PORT_B} port_t;

   state_t state, state_next;
   port_t  owner, owner_next;
   port_t  last, last_next;

   logic              a_elig, b_elig, pick_b;
   logic              own_we, in_range;
   logic [ADDR_W-1:0] own_addr;
   logic [DATA_W-1:0] own_wdata;

   // A port whose ack is high this cycle is masked so a late-dropping requester is not served twice.
   assign a_elig = a_req & ~a_ack;
   assign b_elig = b_req & ~b_ack;

`ifdef DMARB_FIXED_PRIO_EN
   assign pick_b = b_elig & ~a_elig;
`else
   assign pick_b = b_elig & (~a_elig | (last == PORT_A));
`endif

   assign own_we    = (owner == PORT_B) ? b_we    : a_we;
   assign own_addr  = (owner == PORT_B) ? b_addr  : a_addr;
   assign own_wdata = (owner == PORT_B) ? b_wdata : a_wdata;
   assign in_range  = (own_addr >> 2) < ADDR_W'(DEPTH);

   // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
   always_comb begin
      state_next = state;
      owner_next = owner;
      last_next  = last;
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_we     = 1'b0;
      case (state)
         IDLE: begin
            if (a_elig | b_elig) begin
               owner_next = pick_b ? PORT_B : PORT_A;
               last_next  = pick_b ? PORT_B : PORT_A;
               state_next = ACCESS;
            end
         end
         ACCESS: begin
            mem_addr   = own_addr;
            mem_wdata  = own_wdata;
            mem_we     = own_we & in_range & ~reset;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         owner   <= PORT_A;
         last    <= PORT_B;
         a_ack   <= 1'b0;
         b_ack   <= 1'b0;
         a_err   <= 1'b0;
         b_err   <= 1'b0;
         a_rdata <= '0;
         b_rdata <= '0;
      end else begin
         state <= state_next;
         owner <= owner_next;
         last  <= last_next;
         a_ack <= (state == ACCESS) && (owner == PORT_A);
         b_ack <= (state == ACCESS) && (owner == PORT_B);
         a_err <= (state == ACCESS) && (owner == PORT_A) && !in_range;
         b_err <= (state == ACCESS) && (owner == PORT_B) && !in_range;
         if (state == ACCESS && !own_we) begin
            if (owner == PORT_A) a_rdata <= in_range ? mem_rdata : '0;
            else                 b_rdata <= in_range ? mem_rdata : '0;
         end
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural 100-word memory attached.
module tb_data_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        a_req, a_we, b_req, b_we;
   logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
   logic        a_ack, a_err, b_ack, b_err;
   logic [31:0] a_rdata, b_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_we;

   logic [31:0] mem [0:99];
   int          we_total = 0;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   data_mem_arbiter #(.DEPTH(100), .ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .reset(reset),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   assign mem_rdata = (mem_addr[31:2] < 30'd100) ? mem[mem_addr[31:2]] : 32'd0;

   always @(posedge clk) begin
      if (mem_we) begin
         we_total <= we_total + 1;
         if (mem_addr[31:2] < 30'd100) mem[mem_addr[31:2]] <= mem_wdata;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      a_req = 1'b0; b_req = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Issues one request, waits (bounded) for its ack and drops req in the ack cycle.
   task automatic run_access(input bit pb, input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata, output int lat);
      if (pb) begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata; end
      else    begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata; end
      lat = 0;
      do begin
         step();
         lat++;
      end while (!(pb ? b_ack : a_ack) && lat < 10);
      if (lat >= 10) check("ack_timeout", 32'(lat), 32'd2);
      a_req = 1'b0;
      b_req = 1'b0;
   endtask

   logic [1:0] exp_acks [1:8] = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
   int lat;
   int we0;

   initial begin
      for (int i = 0; i < 100; i++) mem[i] = 32'd0;
      mem[1]  = 32'd7;
      mem[5]  = 32'h0000_0055;
      mem[99] = 32'h1234_5678;
      a_we = 1'b0; b_we = 1'b0;
      a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
      do_reset();

      // reset state
      check("rst_a_ack", {31'd0, a_ack}, 32'd0);
      check("rst_b_ack", {31'd0, b_ack}, 32'd0);
      check("rst_a_rdata", a_rdata, 32'd0);
      check("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);

      // 1: A read of word 1
      a_req = 1'b1; a_we = 1'b0; a_addr = 32'd4;
      step();
      check("t1_access_addr", mem_addr, 32'd4);
      check("t1_no_early_ack", {31'd0, a_ack}, 32'd0);
      step();
      check("t1_ack", {31'd0, a_ack}, 32'd1);
      check("t1_rdata", a_rdata, 32'd7);
      check("t1_err", {31'd0, a_err}, 32'd0);
      a_req = 1'b0;
      step();
      check("t1_ack_pulse", {31'd0, a_ack}, 32'd0);
      check("t1_rdata_held", a_rdata, 32'd7);

      // 2: B write then A read back
      we0 = we_total;
      run_access(1'b1, 1'b1, 32'd8, 32'hDEAD_BEEF, lat);
      check("t2_wr_lat", 32'(lat), 32'd2);
      check("t2_wr_err", {31'd0, b_err}, 32'd0);
      check("t2_wr_rdata_kept", b_rdata, 32'd0);
      check("t2_we_cycles", 32'(we_total - we0), 32'd1);
      run_access(1'b0, 1'b0, 32'd8, 32'd0, lat);
      check("t2_rd_lat", 32'(lat), 32'd2);
      check("t2_rd_data", a_rdata, 32'hDEAD_BEEF);

      // 3: both requesting from reset -> A,B,A,B
      reset = 1'b1;
      a_req = 1'b1; a_we = 1'b0; a_addr = 32'd4;
      b_req = 1'b1; b_we = 1'b0; b_addr = 32'd8;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         step();
         check($sformatf("t3_acks_c%0d", k), {30'd0, a_ack, b_ack}, {30'd0, exp_acks[k]});
      end
      check("t3_b_rdata", b_rdata, 32'hDEAD_BEEF);
      a_req = 1'b0; b_req = 1'b0;
      step();

      // 4: out-of-range write and read
      we0 = we_total;
      run_access(1'b0, 1'b1, 32'd400, 32'hAAAA_5555, lat);
      check("t4_wr_err", {31'd0, a_err}, 32'd1);
      check("t4_no_we", 32'(we_total - we0), 32'd0);
      run_access(1'b0, 1'b0, 32'd396, 32'd0, lat);
      check("t4_word99", a_rdata, 32'h1234_5678);
      check("t4_word99_err", {31'd0, a_err}, 32'd0);
      run_access(1'b0, 1'b0, 32'd400, 32'd0, lat);
      check("t4_oor_rdata", a_rdata, 32'd0);
      check("t4_oor_rd_err", {31'd0, a_err}, 32'd1);

      // 5: reset during the ACCESS cycle of a B write
      b_req = 1'b1; b_we = 1'b1; b_addr = 32'd12; b_wdata = 32'hCAFE_F00D;
      step();
      check("t5_in_access", mem_addr, 32'd12);
      reset = 1'b1;
      #1;
      check("t5_we_gated", {31'd0, mem_we}, 32'd0);
      step();
      reset = 1'b0;
      #1;
      check("t5_no_ack", {31'd0, b_ack}, 32'd0);
      check("t5_word3", mem[3], 32'd0);
      check("t5_idle", mem_addr, 32'd0);
      run_access(1'b1, 1'b1, 32'd12, 32'hCAFE_F00D, lat);
      check("t5_reissue_lat", 32'(lat), 32'd2);
      step();
      check("t5_word3_after", mem[3], 32'hCAFE_F00D);

      // 6: A holds req one cycle past its ack
      a_req = 1'b1; a_we = 1'b0; a_addr = 32'd20;
      step();
      step();
      check("t6_ack", {31'd0, a_ack}, 32'd1);
      check("t6_rdata", a_rdata, 32'h0000_0055);
      step();
      check("t6_masked_idle", mem_addr, 32'd0);
      a_req = 1'b0;
      step();
      check("t6_no_second_ack", {31'd0, a_ack}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench timed out");
   end

endmodule
